job_sequencer: RTL and testbench

JOB_SEQUENCER -- requirements
Module: job_sequencer

---
 rtl/job_sequencer.sv | 161 ++++++++++++++++
 tb/tb_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/job_sequencer.sv
// Job sequencer: queues operands in a small FIFO, launches one engine job at a time,
// waits for completion or timeout, and holds the result until downstream accepts it.
module job_sequencer #(
    parameter int DATA_W  = 32,
    parameter int RES_W   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              start,
    output logic [DATA_W-1:0] x_out,
    input  logic              done,
    input  logic [RES_W-1:0]  res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_timeout,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic               start_q, start_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ovalid_q, ovalid_d;
    logic [RES_W-1:0]   odata_q, odata_d;
    logic               otime_q, otime_d;
    logic               full, empty, push, pop;

    // Handshake: a job transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        x_d      = x_q;
        start_d  = 1'b0;
        cnt_d    = cnt_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        otime_d  = otime_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    x_d     = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (done) begin
                    odata_d  = res;
                    ovalid_d = 1'b1;
                    otime_d  = 1'b0;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == 16'(TIMEOUT)) begin
                        odata_d  = '0;
                        ovalid_d = 1'b1;
                        otime_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            x_q      <= '0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            otime_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            x_q      <= x_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            otime_q  <= otime_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready    = !full;
    assign start       = start_q;
    assign x_out       = x_q;
    assign out_valid   = ovalid_q;
    assign out_data    = odata_q;
    assign out_timeout = otime_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Directed bench for job_sequencer: engine model driven from one initial block,
// issued operands and expected results tracked in scoreboard queues.
module tb_job_sequencer;

    localparam int DATA_W  = 32;
    localparam int RES_W   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 12;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              start;
    logic [DATA_W-1:0] x_out;
    logic              done;
    logic [RES_W-1:0]  res;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              out_timeout;
    logic              busy;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    logic [RES_W:0]    exp_q[$];
    logic [DATA_W-1:0] exp_x_q[$];
    logic [DATA_W-1:0] cur_x;
    logic [RES_W:0]    last_exp;

    job_sequencer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start), .x_out(x_out), .done(done), .res(res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_timeout(out_timeout), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // driver tasks
    task automatic push_job(input logic [DATA_W-1:0] d, input logic exp_ready);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready", in_ready, exp_ready);
        if (exp_ready) exp_x_q.push_back(d);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " start"}, start, 1);
        check({tag, " issue_state"}, dbg_state, 1);
        check({tag, " queued"}, exp_x_q.size() != 0, 1);
        if (exp_x_q.size() != 0) begin
            cur_x = exp_x_q.pop_front();
            check({tag, " x_out"}, x_out, cur_x);
        end
    endtask

    // Called at the ISSUE cycle; done (or nothing) is driven on WAIT cycle k.
    task automatic engine(input string tag, input int k, input logic [RES_W-1:0] r, input bit give_done);
        for (int i = 0; i < k; i++) begin
            tick();
            if (i == 0) check({tag, " wait_entry"}, dbg_state, 2);
        end
        check({tag, " still_wait"}, dbg_state, 2);
        check({tag, " no_early_valid"}, out_valid, 0);
        if (give_done) begin
            done = 1'b1;
            res  = r;
            exp_q.push_back({1'b0, r});
        end else begin
            exp_q.push_back({1'b1, {RES_W{1'b0}}});
        end
        tick();
        done = 1'b0;
        res  = $urandom;
    endtask

    task automatic check_result(input string tag);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " hold_state"}, dbg_state, 3);
        check({tag, " start_low"}, start, 0);
        check({tag, " x_stable"}, x_out, cur_x);
        check({tag, " sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            last_exp = exp_q.pop_front();
            check({tag, " out_timeout"}, out_timeout, last_exp[RES_W]);
            check({tag, " out_data"}, out_data, last_exp[RES_W-1:0]);
        end
    endtask

    task automatic accept(input string tag, input int hold);
        int s0 = start_cnt;
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) begin
            check({tag, " bp_valid"}, out_valid, 1);
            check({tag, " bp_data"}, out_data, last_exp[RES_W-1:0]);
            check({tag, " bp_timeout"}, out_timeout, last_exp[RES_W]);
            check({tag, " bp_no_start"}, start_cnt, s0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid_clear"}, out_valid, 0);
        check({tag, " idle"}, dbg_state, 0);
        check({tag, " busy_low"}, busy, 0);
    endtask

    task automatic serve(input string tag, input int k, input logic [RES_W-1:0] r,
                         input bit give_done, input int hold, input bit more);
        wait_start(tag);
        engine(tag, k, r, give_done);
        check_result(tag);
        accept(tag, hold);
        tick();
        if (more) begin
            check({tag, " next_pop"}, start, 1);
        end else begin
            check({tag, " stay_idle"}, busy, 0);
            check({tag, " no_start"}, start, 0);
        end
    endtask

    initial begin
        int n;
        int s0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        done = 1'b0; res = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst in_ready", in_ready, 1);
        check("rst start", start, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_timeout", out_timeout, 0);
        check("rst out_data", out_data, 0);
        check("rst x_out", x_out, 0);
        check("rst busy", busy, 0);
        check("rst state", dbg_state, 0);

        // Spurious done with nothing queued.
        done = 1'b1; res = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) tick();
        done = 1'b0;
        check("spur out_valid", out_valid, 0);
        check("spur state", dbg_state, 0);
        check("spur start_cnt", start_cnt, 0);

        // Single job with 1-cycle pop / issue latency.
        push_job(32'h0000_00A5, 1'b1);
        check("lat idle_after_push", dbg_state, 0);
        check("lat no_start_yet", start, 0);
        tick();
        wait_start("single");
        engine("single", 10, 32'h1234, 1'b1);
        check_result("single");
        check("single one_start", start_cnt, 1);
        accept("single", 0);
        tick();
        check("single stay_idle", busy, 0);

        // Fill the FIFO while the first job is stuck in WAIT (it will time out).
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) push_job(32'h100 + i, 1'b1);
        push_job(32'hBAD0_0BAD, 1'b0);
        check("full in_ready", in_ready, 0);
        check("full one_in_flight", start_cnt, s0 + 1);
        cur_x = exp_x_q.pop_front();
        check("full x_out", x_out, cur_x);
        exp_q.push_back({1'b1, {RES_W{1'b0}}});
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        // Job entered WAIT at the 3rd push edge; 6 push edges have elapsed.
        check("timeout latency", n, TIMEOUT - 3);
        check_result("timeout");
        accept("timeout", 0);
        tick();
        check("timeout next_pop", start, 1);
        check("drain in_ready", in_ready, 1);

        serve("fifo1", 3, 32'hCAFE_0001, 1'b1, 0, 1'b1);
        serve("prio", TIMEOUT, 32'hCAFE_0002, 1'b1, 0, 1'b1);
        serve("bp", 1, 32'hCAFE_0003, 1'b1, 20, 1'b1);
        serve("fifo4", $urandom_range(2, TIMEOUT - 1), $urandom, 1'b1, 2, 1'b0);
        check("drain empty", exp_x_q.size(), 0);

        // Reset while a job waits and two more are queued.
        push_job(32'h200, 1'b1);
        push_job(32'h201, 1'b1);
        push_job(32'h202, 1'b1);
        check("mid wait_state", dbg_state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid state", dbg_state, 0);
        check("mid in_ready", in_ready, 1);
        check("mid out_valid", out_valid, 0);
        check("mid x_out", x_out, 0);
        check("mid out_data", out_data, 0);
        check("mid start", start, 0);
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("mid no_start", start_cnt, s0);
        check("mid no_valid", out_valid, 0);
        check("mid busy", busy, 0);
        exp_x_q.delete();
        exp_q.delete();

        push_job(32'h0000_0077, 1'b1);
        tick();
        serve("recover", 5, 32'h5A5A_5A5A, 1'b1, 0, 1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
